// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: START / WRITE / READ / STOP commands, SCL built from
// quarter-period timing, slave clock stretching honoured, one response per command.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl_out,
  output logic       sda_out,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic [2:0] dbg_state
);

  // Handshake: a command transfers on a cycle with cmd_valid && cmd_ready (ready only in
  // IDLE); rsp_valid is a one-cycle pulse with no back-pressure, exactly one per command.

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] Q_LAST = CW'(CLK_DIV - 1);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WBIT  = 3'd2,
    S_RBIT  = 3'd3,
    S_ACKB  = 3'd4,
    S_STOP  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_q;
  logic [CW-1:0]   r_qcnt;
  logic [2:0]      r_bit;
  logic [1:0]      r_op;
  logic [7:0]      r_tx;
  logic [7:0]      r_rx;
  logic            r_ack;
  logic            r_nack_smp;
  logic            r_busy;
  logic [7:0]      r_rsp_data;
  logic            r_rsp_nack;
  logic            r_rsp_err;

  logic            w_active;
  logic            w_accept;
  logic            w_legal;
  logic            w_stall;
  logic            w_q_end;
  logic            w_last_q;
  logic            w_scl_oe;
  logic            w_sda_oe;

  assign w_active = (r_state == S_START) || (r_state == S_WBIT) || (r_state == S_RBIT) ||
                    (r_state == S_ACKB)  || (r_state == S_STOP);
  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_legal  = (cmd_op == OP_START) || r_busy;
  // A released SCL still read low means a slave is stretching: freeze the quarter timer.
  assign w_stall  = w_active && !w_scl_oe && !scl_in;
  assign w_q_end  = w_active && (r_qcnt == '0) && !w_stall;
  assign w_last_q = w_q_end && (r_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!w_legal) begin
            w_state_nxt = S_RESP;
          end else begin
            case (cmd_op)
              OP_START: w_state_nxt = S_START;
              OP_WRITE: w_state_nxt = S_WBIT;
              OP_READ:  w_state_nxt = S_RBIT;
              default:  w_state_nxt = S_STOP;
            endcase
          end
        end
      end
      S_START, S_STOP, S_ACKB: begin
        if (w_last_q) w_state_nxt = S_RESP;
      end
      S_WBIT, S_RBIT: begin
        if (w_last_q && (r_bit == 3'd7)) w_state_nxt = S_ACKB;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line drive per state and quarter; SCL stays held low between commands while the bus is owned.
  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        w_scl_oe = r_busy;
      end
      S_START: begin
        case (r_q)
          2'd0:    w_scl_oe = r_busy;
          2'd1:    w_scl_oe = 1'b0;
          2'd2:    w_sda_oe = 1'b1;
          default: begin
            w_scl_oe = 1'b1;
            w_sda_oe = 1'b1;
          end
        endcase
      end
      S_WBIT: begin
        w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
        w_sda_oe = ~r_tx[7];
      end
      S_RBIT: begin
        w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
      end
      S_ACKB: begin
        w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
        w_sda_oe = (r_op == OP_READ) && r_ack;
      end
      S_STOP: begin
        w_scl_oe = (r_q == 2'd0);
        w_sda_oe = (r_q == 2'd0) || (r_q == 2'd1);
      end
      default: begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= 2'd0;
      r_qcnt     <= Q_LAST;
      r_bit      <= 3'd0;
      r_op       <= OP_START;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_ack      <= 1'b0;
      r_nack_smp <= 1'b0;
      r_busy     <= 1'b0;
      r_rsp_data <= 8'h00;
      r_rsp_nack <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_op       <= cmd_op;
      r_tx       <= cmd_data;
      r_ack      <= cmd_ack;
      r_q        <= 2'd0;
      r_qcnt     <= Q_LAST;
      r_bit      <= 3'd0;
      r_rx       <= 8'h00;
      r_nack_smp <= 1'b0;
      if (!w_legal) begin
        r_rsp_data <= 8'h00;
        r_rsp_nack <= 1'b0;
        r_rsp_err  <= 1'b1;
      end
    end else if (w_active && !w_stall) begin
      if (r_qcnt != '0) begin
        r_qcnt <= r_qcnt - CW'(1);
      end else begin
        r_qcnt <= Q_LAST;
        r_q    <= r_q + 2'd1;
        // SDA is sampled on the final cycle of Q2, just before SCL is pulled low again.
        if (r_q == 2'd2) begin
          if (r_state == S_RBIT) r_rx <= {r_rx[6:0], sda_in};
          if (r_state == S_ACKB) r_nack_smp <= sda_in;
        end
        if (r_q == 2'd3) begin
          if ((r_state == S_WBIT) || (r_state == S_RBIT)) begin
            r_bit <= r_bit + 3'd1;
            r_tx  <= {r_tx[6:0], 1'b0};
          end
          if (r_state == S_START) r_busy <= 1'b1;
          if (r_state == S_STOP)  r_busy <= 1'b0;
          if ((r_state == S_START) || (r_state == S_STOP) || (r_state == S_ACKB)) begin
            r_rsp_err  <= 1'b0;
            r_rsp_data <= (r_op == OP_READ)  ? r_rx : 8'h00;
            r_rsp_nack <= (r_op == OP_WRITE) ? r_nack_smp : 1'b0;
          end
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_nack  = r_rsp_nack;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign scl_out   = 1'b0;
  assign sda_out   = 1'b0;
  assign scl_oe    = w_scl_oe;
  assign sda_oe    = w_sda_oe;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: directed scenarios plus random commands against an
// open-drain bus with a behavioural slave (ACK, read data, clock stretching).
module tb_i2c_master_ctrl;

  localparam int D = 4;
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef struct packed {
    logic [7:0]  data;
    logic        nack;
    logic        err;
    logic        busy;
    logic [15:0] lat;
    logic [15:0] scl_n;
    logic [15:0] sda_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_err;
  logic       busy;
  logic       scl_out;
  logic       sda_out;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;
  logic [2:0] dbg_state;

  exp_t       exp_q[$];
  logic [7:0] wr_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic       m_busy  = 1'b0;

  // slave configuration, picked up by the slave when cfg_seq changes
  int         cfg_seq = 0;
  int         cfg_mode = 0;
  logic [7:0] cfg_rbyte = 8'h00;
  logic       cfg_ack_en = 1'b0;
  int         cfg_str_bit = 0;
  int         cfg_str_len = 0;

  // slave state
  int         s_seen, s_mode, s_bit, s_sbit, s_slen, s_cnt;
  logic [7:0] s_rbyte, s_cap;
  logic       s_ack, s_armed, s_hold, s_scl_prev;
  logic       s_sda_low = 1'b0;
  logic       s_hold_q  = 1'b0;

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .rsp_err(rsp_err),
    .busy(busy), .scl_out(scl_out), .sda_out(sda_out), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_in), .sda_in(sda_in), .dbg_state(dbg_state)
  );

  // clock / reset block and resolved open-drain bus
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign scl_in = ~(scl_oe | s_hold_q);
  assign sda_in = ~(sda_oe | s_sda_low);

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural slave: counts SCL falls to know the bit slot, acks/sends data, stretches once.
  always @(negedge clk) begin
    if (rst) begin
      s_seen = cfg_seq; s_mode = 0; s_bit = 0; s_hold = 1'b0; s_armed = 1'b0;
      s_cnt = 0; s_cap = 8'h00; s_scl_prev = 1'b1; s_sda_low = 1'b0; s_hold_q = 1'b0;
    end else begin
      if (cfg_seq != s_seen) begin
        s_seen = cfg_seq; s_mode = cfg_mode; s_rbyte = cfg_rbyte; s_ack = cfg_ack_en;
        s_bit = 0; s_armed = (cfg_str_len != 0); s_sbit = cfg_str_bit; s_slen = cfg_str_len;
        s_hold = 1'b0; s_cnt = 0; s_cap = 8'h00;
      end else begin
        if (s_scl_prev && !scl_in) s_bit++;
        if (!s_scl_prev && scl_in && s_mode == 1 && s_bit < 8) begin
          s_cap = {s_cap[6:0], sda_in};
          if (s_bit == 7) begin
            if (wr_q.size() == 0) chk("wr_byte_unexpected", 1, 0);
            else chk("wr_byte_on_bus", int'(s_cap), int'(wr_q.pop_front()));
          end
        end
        if (s_armed && s_bit == s_sbit && scl_oe) begin
          s_hold = 1'b1; s_armed = 1'b0; s_cnt = 0;
        end else if (s_hold && !scl_oe) begin
          if (s_cnt == s_slen) s_hold = 1'b0;
          else s_cnt++;
        end
      end
      s_scl_prev = scl_in;
      s_sda_low = 1'b0;
      if (s_mode == 2 && s_bit < 8) s_sda_low = ~s_rbyte[3'(7 - s_bit)];
      if (s_mode == 1 && s_bit == 8) s_sda_low = s_ack;
      s_hold_q = s_hold;
    end
  end

  // Monitor: per-command latency and line-drive counts, popped against the scoreboard.
  int   mon_acc, mon_scl, mon_sda;
  logic mon_win = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      mon_win = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_err",  int'(rsp_err),  int'(mon_e.err));
          chk("rsp_data", int'(rsp_data), int'(mon_e.data));
          chk("rsp_nack", int'(rsp_nack), int'(mon_e.nack));
          chk("busy",     int'(busy),     int'(mon_e.busy));
          chk("latency",  cyc - mon_acc,  int'(mon_e.lat));
          chk("scl_low_cycles", mon_scl,  int'(mon_e.scl_n));
          chk("sda_low_cycles", mon_sda,  int'(mon_e.sda_n));
        end
        mon_win = 1'b0;
      end else if (mon_win) begin
        if (scl_oe) mon_scl++;
        if (sda_oe) mon_sda++;
      end
      if (cmd_valid && cmd_ready) begin
        mon_win = 1'b1; mon_scl = 0; mon_sda = 0; mon_acc = cyc;
      end
    end
  end

  // Reference model + driver: expected response from bus rules, slave set up, command sent.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic a,
                       input logic slave_en, input logic [7:0] rbyte,
                       input int str_bit, input int str_len);
    exp_t e;
    logic legal;
    int   zeros;
    int   n;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    legal = (op == OP_START) || m_busy;
    e = '0;
    e.err = !legal;
    cfg_mode = 0; cfg_str_len = 0; cfg_str_bit = str_bit;
    cfg_rbyte = rbyte; cfg_ack_en = slave_en;
    if (!legal) begin
      e.lat = 16'd1;
    end else begin
      case (op)
        OP_START: begin
          e.lat = 16'(4 * D + 1); e.scl_n = 16'(m_busy ? 2 * D : D); e.sda_n = 16'(2 * D);
          m_busy = 1'b1;
        end
        OP_STOP: begin
          e.lat = 16'(4 * D + 1); e.scl_n = 16'(D); e.sda_n = 16'(2 * D);
          m_busy = 1'b0;
        end
        OP_WRITE: begin
          zeros = 0;
          for (int i = 0; i < 8; i++) if (!d[i]) zeros++;
          e.lat   = 16'(36 * D + 1 + str_len);
          e.scl_n = 16'(18 * D);
          e.sda_n = 16'(zeros * 4 * D + ((str_len != 0 && !d[3'(7 - str_bit)]) ? str_len : 0));
          e.nack  = !slave_en;
          cfg_mode = 1; cfg_str_len = str_len;
          wr_q.push_back(d);
        end
        default: begin
          e.lat   = 16'(36 * D + 1 + str_len);
          e.scl_n = 16'(18 * D);
          e.sda_n = 16'(a ? 4 * D : 0);
          e.data  = rbyte;
          cfg_mode = 2; cfg_str_len = str_len;
        end
      endcase
    end
    e.busy = m_busy;
    exp_q.push_back(e);
    cfg_seq++;
    cmd_op = op; cmd_data = d; cmd_ack = a; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] op;
    int n;
    int sl;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00; cmd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_scl_oe", int'(scl_oe), 0);
    chk("reset_sda_oe", int'(sda_oe), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_nack", int'(rsp_nack), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk); #1;

    // directed: ACKed write, unanswered write, NACKed read, stretched write, illegal write
    issue(OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0);
    issue(OP_WRITE, 8'hA5, 1'b0, 1'b1, 8'h00, 0, 0);
    issue(OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0, 0);
    issue(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
    issue(OP_WRITE, 8'h50, 1'b0, 1'b0, 8'h00, 0, 0);
    issue(OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
    issue(OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0);
    issue(OP_READ,  8'h00, 1'b0, 1'b1, 8'h3C, 0, 0);
    issue(OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0);
    issue(OP_WRITE, 8'hFF, 1'b0, 1'b1, 8'h00, 3, 20);
    issue(OP_STOP,  8'h00, 1'b0, 1'b1, 8'h00, 0, 0);
    issue(OP_WRITE, 8'h12, 1'b0, 1'b1, 8'h00, 0, 0);

    // reset in the middle of bit 5 of a write
    issue(OP_START, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0);
    issue(OP_WRITE, 8'hC3, 1'b0, 1'b1, 8'h00, 0, 0);
    n = 0;
    while (s_bit != 5 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_bit5", s_bit, 5);
    repeat (D + 1) @(posedge clk);
    #1;
    exp_q.delete();
    wr_q.delete();
    m_busy = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_scl_oe", int'(scl_oe), 0);
    chk("midrst_sda_oe", int'(sda_oe), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk); #1;

    // random commands, with ACK/NACK slaves and occasional stretching
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      sl = 0;
      if ((op == OP_WRITE || op == OP_READ) && $urandom_range(0, 3) == 0) sl = $urandom_range(1, 12);
      issue(op, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            8'($urandom), $urandom_range(0, 7), sl);
    end
    if (m_busy) issue(OP_STOP, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0);

    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("responses_left", exp_q.size(), 0);
    chk("wr_bytes_left", wr_q.size(), 0);
    chk("final_busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
